dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer for the single-ported `data_mem` block. It shares the data memory between port 0 (CPU load/store unit) and port 1 (debug/loader master), serialising their requests with a request/acknowledge handshake. It drives the memory's `mem_read`, `mem_write`, `addr` and `write_data` inputs, and returns `read_data` to the granted requester. It sits between the CPU datapath, the loader and `data_mem`.

## Interface
- `DATA_W`, 32, data width of memory and both ports
- `ADDR_W`, 32, byte-address width
- `DMEM_SIZE`, 64, implemented memory depth in words; word index = `addr[ADDR_W-1:2]`
- `clk` input 1 — single clock; all state updates on rising edge
- `rst` input 1 — synchronous, active-high reset
- `req0` / `req1` input 1 — request from port 0 / port 1; held high until matching `ack`
- `we0` / `we1` input 1 — 1 = write, 0 = read; stable while `req` high
- `addr0` / `addr1` input ADDR_W — byte address; stable while `req` high
- `wdata0` / `wdata1` input DATA_W — write data; stable while `req` high
- `ack0` / `ack1` output 1 — one-cycle completion pulse
- `err0` / `err1` output 1 — valid with `ack`; 1 = word index ≥ DMEM_SIZE
- `rdata0` / `rdata1` output DATA_W — read result, valid with `ack` for reads
- `mem_read`, `mem_write` output 1 — memory strobes
- `mem_addr` output ADDR_W, `mem_wdata` output DATA_W — memory address and write data
- `mem_rdata` input DATA_W — memory read data, combinational from `mem_addr`

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if `req0` or `req1` is high, pick a winner. Latch owner, `we`, `addr`, `wdata` and the range check into internal registers, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS (one cycle):
  - In range: assert `mem_read` (read) or `mem_write` (write). `mem_addr`/`mem_wdata` come from the latched copy. The memory performs the write on the closing edge; `mem_rdata` is captured into the owner's `rdata` register on the same edge.
  - Out of range: no strobe asserted; `rdata` is loaded with 0 and the error flag is latched.
  - Next state: RESP.
- RESP: `ack` of the owner = 1; `err` of the owner = latched flag. Update last-granted port, then go to IDLE. A `req` still high in the IDLE cycle that follows counts as a new request.
- `rdata0`/`rdata1` hold their last value until the next completed read on that port. Write and error completions also load 0 into `rdata`.
- `mem_addr`/`mem_wdata` are 0 outside ACCESS.
- Only the owner's `ack`/`err` ever assert; at most one `ack` is high per cycle.

## Timing
- Reset values:
  - state IDLE
  - `ack0`/`ack1`/`err0`/`err1`/`mem_read`/`mem_write` = 0
  - `mem_addr`/`mem_wdata`/`rdata0`/`rdata1` = 0
  - last-granted = port 1 (so port 0 wins the first tie)
- Latency: `req` sampled high in IDLE at edge N. ACCESS strobe during cycle N+1. `ack` during cycle N+2.
- Throughput: one access per 3 cycles when requests are back-to-back.
- Simultaneous `req0` and `req1` in IDLE resolve per Configuration.
- A request arriving during ACCESS or RESP waits. It is evaluated in the next IDLE cycle.
- `rst` asserted in ACCESS or RESP: the FSM returns to IDLE at that edge. No `ack` is issued. The strobes are 0 from the next cycle. A write whose ACCESS edge coincides with `rst` is not guaranteed to complete.
- Dropping `req` before `ack` is illegal. The access still completes and `ack` is still pulsed.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. On a tie, the port not granted most recently wins.
- Not defined: fixed priority. Port 0 always wins ties; port 1 is served only when `req0` is low in IDLE. The last-granted register is omitted.

## Structure
- Shared package `dmem_pkg`:
  - state encoding constants (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - default `DMEM_SIZE` = 64
  - port-index constants
- Optional sub-module `dmem_arb_pick`: combinational winner select from `req0`, `req1` and last-granted, containing the `DMEM_ARB_RR_EN` ifdef. Everything else lives in `dmem_arbiter`.

## Test plan
- Reset then single access:
  - port 0 write `addr0`=0x8, `wdata0`=0xDEADBEEF → `mem_write`=1 for one cycle with `mem_addr`=0x8, then `ack0`=1 with `err0`=0.
  - Port 0 read of 0x8 → `rdata0`=0xDEADBEEF with `ack0`, two cycles after the request is sampled.
- Simultaneous `req0`/`req1` reads, held for 4 transactions:
  - with `DMEM_ARB_RR_EN`: acks alternate 0,1,0,1.
  - without it: port 0 is acked on every transaction and `ack1` never asserts while `req0` stays high.
- Out of range: port 1 read `addr1`=0x100 (index 64) → no `mem_read`, `ack1`=1, `err1`=1, `rdata1`=0.
- Preloaded memory: word 5 = 0x12345678. Port 1 reads 0x14 while port 0 is in RESP → port 1 access starts in the next IDLE, `rdata1`=0x12345678.
- `rst` pulsed during ACCESS of a port 0 read → no `ack0`. Next cycle the outputs equal the reset values and the FSM is in IDLE. A subsequent request completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// default memory depth and port indices.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_state_t;

  localparam int DMEM_SIZE_DEFAULT = 64;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the two requesters.
// Build option DMEM_ARB_RR_EN: round-robin ties; otherwise fixed priority to port 0.
module dmem_arb_pick
  import dmem_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef DMEM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_port
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_port  = PORT0;
    if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
      // On a tie the port that was not served most recently goes next
      grant_port = (last_grant == PORT0) ? PORT1 : PORT0;
`else
      grant_port = PORT0;
`endif
    end else if (req1) begin
      grant_port = PORT1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the single-ported data memory.
// Build option DMEM_ARB_RR_EN selects round-robin tie breaking (default: fixed priority).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DMEM_SIZE = DMEM_SIZE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-3:0] SIZE_IDX = (ADDR_W-2)'(DMEM_SIZE);

  dmem_state_t       state;
  dmem_state_t       state_nxt;
  logic              owner;
  logic              lat_we;
  logic              lat_err;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              grant_valid;
  logic              grant_port;
  logic              sel_we;
  logic              sel_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] capture;

`ifdef DMEM_ARB_RR_EN
  logic last_grant;
`endif

  dmem_arb_pick u_pick (
    .req0        (req0),
    .req1        (req1),
`ifdef DMEM_ARB_RR_EN
    .last_grant  (last_grant),
`endif
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  // Request fields of the winning port, with the range check done up front
  always_comb begin
    sel_we    = (grant_port == PORT1) ? we1    : we0;
    sel_addr  = (grant_port == PORT1) ? addr1  : addr0;
    sel_wdata = (grant_port == PORT1) ? wdata1 : wdata0;
    sel_err   = (sel_addr[ADDR_W-1:2] >= SIZE_IDX);
    capture   = (lat_err || lat_we) ? '0 : mem_rdata;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    err0      = 1'b0;
    err1      = 1'b0;
    unique case (state)
      ACCESS: begin
        mem_read  = !lat_err && !lat_we;
        mem_write = !lat_err &&  lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
      end
      RESP: begin
        ack0 = (owner == PORT0);
        ack1 = (owner == PORT1);
        err0 = (owner == PORT0) && lat_err;
        err1 = (owner == PORT1) && lat_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= PORT0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
`ifdef DMEM_ARB_RR_EN
      last_grant <= PORT1;
`endif
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            owner     <= grant_port;
            lat_we    <= sel_we;
            lat_err   <= sel_err;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
          end
        end
        // Writes and out-of-range accesses clear the owner's read register
        ACCESS: begin
          if (owner == PORT0) rdata0 <= capture;
          else                rdata1 <= capture;
        end
        RESP: begin
`ifdef DMEM_ARB_RR_EN
          last_grant <= owner;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 64-word behavioural memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:63];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .ack0      (ack0),
    .err0      (err0),
    .rdata0    (rdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack1      (ack1),
    .err1      (err1),
    .rdata1    (rdata1),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (load_en) mem[5] <= 32'h1234_5678;
    else if (mem_write && (mem_addr[31:2] < 30'd64)) mem[mem_addr[7:2]] <= mem_wdata;
  end

  assign mem_rdata = (mem_addr[31:2] < 30'd64) ? mem[mem_addr[7:2]] : 32'h0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  // One uncontended access from idle: strobe one cycle after sampling, ack the next
  task automatic applyStimulus(input bit port, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input bit exp_err, input string tag);
    @(posedge clk); #1;
    if (port == 1'b0) begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wdata; end
    else              begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wdata; end
    @(posedge clk); @(negedge clk);
    checkOutput({tag, "_mem_read"},  32'(mem_read),  32'(!exp_err && !we));
    checkOutput({tag, "_mem_write"}, 32'(mem_write), 32'(!exp_err && we));
    if (!exp_err) checkOutput({tag, "_mem_addr"}, mem_addr, addr);
    if (!exp_err && we) checkOutput({tag, "_mem_wdata"}, mem_wdata, wdata);
    @(negedge clk);
    checkOutput({tag, "_ack"},   32'(port ? ack1 : ack0), 32'd1);
    checkOutput({tag, "_other_ack"}, 32'(port ? ack0 : ack1), 32'd0);
    checkOutput({tag, "_err"},   32'(port ? err1 : err0), 32'(exp_err));
    checkOutput({tag, "_rdata"}, port ? rdata1 : rdata0, exp_rdata);
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0; load_en = 0;
    @(negedge clk);
    checkOutput("rst_ack0",   32'(ack0), 0);
    checkOutput("rst_ack1",   32'(ack1), 0);
    checkOutput("rst_err",    32'(err0 | err1), 0);
    checkOutput("rst_strobe", 32'(mem_read | mem_write), 0);
    checkOutput("rst_maddr",  mem_addr, 0);
    checkOutput("rst_mwdata", mem_wdata, 0);
    checkOutput("rst_rdata0", rdata0, 0);
    checkOutput("rst_rdata1", rdata1, 0);

    applyStimulus(0, 1, 32'h8, 32'hDEAD_BEEF, 32'h0, 0, "p0_write");
    applyStimulus(0, 0, 32'h8, 32'h0, 32'hDEAD_BEEF, 0, "p0_read");

    // Port 1 request raised while port 0 is in RESP waits for the next IDLE
    @(posedge clk); #1;
    req0 = 1; we0 = 0; addr0 = 32'h8;
    @(posedge clk); @(posedge clk); #1;
    req1 = 1; we1 = 0; addr1 = 32'h14;
    @(negedge clk);
    checkOutput("wait_ack0", 32'(ack0), 1);
    checkOutput("wait_ack1", 32'(ack1), 0);
    @(posedge clk); #1;
    req0 = 0;
    @(negedge clk);
    checkOutput("wait_idle_strobe", 32'(mem_read), 0);
    @(posedge clk); @(negedge clk);
    checkOutput("wait_p1_read", 32'(mem_read), 1);
    checkOutput("wait_p1_addr", mem_addr, 32'h14);
    @(negedge clk);
    checkOutput("wait_p1_ack",   32'(ack1), 1);
    checkOutput("wait_p1_rdata", rdata1, 32'h1234_5678);
    checkOutput("wait_p0_hold",  rdata0, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    req1 = 0;

    applyStimulus(1, 0, 32'h100, 32'h0, 32'h0, 1, "p1_oor");

    // Both ports held requesting reads across four transactions
    @(posedge clk); #1;
    req0 = 1; we0 = 0; addr0 = 32'h8;
    req1 = 1; we1 = 0; addr1 = 32'h14;
    for (int t = 0; t < 4; t++) begin
      bit exp_p;
`ifdef DMEM_ARB_RR_EN
      exp_p = t[0];
`else
      exp_p = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("tie%0d_ack0", t), 32'(ack0), 32'(!exp_p));
      checkOutput($sformatf("tie%0d_ack1", t), 32'(ack1), 32'(exp_p));
      if (exp_p) checkOutput($sformatf("tie%0d_rdata1", t), rdata1, 32'h1234_5678);
      else       checkOutput($sformatf("tie%0d_rdata0", t), rdata0, 32'hDEAD_BEEF);
      @(posedge clk);
    end
    #1 req0 = 0; req1 = 0;

    // Reset during ACCESS of a port 0 read
    @(posedge clk); #1;
    req0 = 1; we0 = 0; addr0 = 32'h8;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    checkOutput("rstacc_strobe", 32'(mem_read), 1);
    @(posedge clk); #1;
    rst = 0; req0 = 0;
    @(negedge clk);
    checkOutput("rstacc_ack0",   32'(ack0 | ack1), 0);
    checkOutput("rstacc_strb",   32'(mem_read | mem_write), 0);
    checkOutput("rstacc_maddr",  mem_addr, 0);
    checkOutput("rstacc_rdata0", rdata0, 0);
    checkOutput("rstacc_rdata1", rdata1, 0);
    @(negedge clk);
    checkOutput("rstacc_noack", 32'(ack0 | ack1), 0);

    applyStimulus(0, 0, 32'h8, 32'h0, 32'hDEAD_BEEF, 0, "post_rst_read");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
